// File: rtl/cas_writer.sv
// Cassette-save capture: measures FSK cycle periods on the SVI tape-write level,
// frames the decoded bits into bytes and writes them sequentially into a capture RAM.
module cas_writer #(
  parameter int unsigned AW         = 16,
  parameter int unsigned SHORT_MIN  = 4000,
  parameter int unsigned LONG_THR   = 13333,
  parameter int unsigned GAP_MAX    = 26666,
  parameter int unsigned LEADER_MIN = 64
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          clk_en_i,
  input  logic          tap_i,
  input  logic          motor_i,
  input  logic          rewind_i,
  output logic          wr_o,
  output logic [AW-1:0] addr_o,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          ferr_o,
  output logic [1:0]    state_o
);

  localparam int unsigned CW = 16;
  localparam int unsigned LW = $clog2(LEADER_MIN + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SYNC       = 2'd1,
    WAIT_START = 2'd2,
    DATA       = 2'd3
  } state_t;

  logic          tap_meta, tap_sync, tap_prev;
  logic          edge_c, glitch_c, sym_s_c, sym_l_c, gap_c;
  logic [CW-1:0] cnt_q;

  state_t        state_q, state_d;
  logic          half_q, half_d;
  logic [LW-1:0] lead_q, lead_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [1:0]    stop_q, stop_d;
  logic          wr_q, wr_d;
  logic [7:0]    data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          full_q, full_d;
  logic          ferr_q, ferr_d;
  logic          bit_vld_c, bit_val_c, phase_err_c;

  // 2-flop synchronizer plus one stage for rising-edge detection
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tap_meta <= 1'b0;
      tap_sync <= 1'b0;
      tap_prev <= 1'b0;
    end else begin
      tap_meta <= tap_i;
      tap_sync <= tap_meta;
      tap_prev <= tap_sync;
    end
  end

  assign edge_c   = tap_sync & ~tap_prev;
  assign glitch_c = edge_c && (cnt_q < CW'(SHORT_MIN));
  assign sym_s_c  = edge_c && !glitch_c && (cnt_q < CW'(LONG_THR));
  assign sym_l_c  = edge_c && (cnt_q >= CW'(LONG_THR));
  assign gap_c    = clk_en_i && !edge_c && (cnt_q == CW'(GAP_MAX - 1));

  // Period counter: a glitch edge leaves it running so the real cycle is measured whole
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                               cnt_q <= '0;
    else if (edge_c && !glitch_c)                 cnt_q <= '0;
    else if (clk_en_i && cnt_q != CW'(GAP_MAX))   cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      half_q  <= 1'b0;
      lead_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      stop_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      full_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      lead_q  <= lead_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      stop_q  <= stop_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    lead_d      = lead_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    stop_d      = stop_q;
    wr_d        = 1'b0;
    data_d      = data_q;
    addr_d      = addr_q;
    full_d      = full_q;
    ferr_d      = ferr_q;
    bit_vld_c   = 1'b0;
    bit_val_c   = 1'b0;
    phase_err_c = 1'b0;

    // Symbol to bit: L is a 0, a pair of S is a 1; S then L is a phase slip
    if (sym_s_c) begin
      if (half_q) begin
        bit_vld_c = 1'b1;
        bit_val_c = 1'b1;
        half_d    = 1'b0;
      end else begin
        half_d    = 1'b1;
      end
    end else if (sym_l_c) begin
      bit_vld_c = 1'b1;
      if (half_q) begin
        half_d      = 1'b0;
        phase_err_c = (state_q != SYNC);
      end
    end else if (gap_c) begin
      half_d = 1'b0;
    end

    // Address advances the cycle after a write; the last address sticks and raises full
    if (wr_q) begin
      if (addr_q == '1) full_d = 1'b1;
      else              addr_d = addr_q + AW'(1);
    end

    case (state_q)
      IDLE: begin
        if (motor_i) begin
          state_d = SYNC;
          lead_d  = '0;
        end
      end
      SYNC: begin
        if (gap_c) begin
          lead_d = '0;
        end else if (bit_vld_c) begin
          if (bit_val_c) begin
            if (lead_q != LW'(LEADER_MIN)) lead_d = lead_q + LW'(1);
          end else if (lead_q == LW'(LEADER_MIN)) begin
            state_d = DATA;
            bcnt_d  = '0;
          end else begin
            lead_d = '0;
          end
        end
      end
      DATA: begin
        if (gap_c || phase_err_c) begin
          ferr_d  = 1'b1;
          state_d = SYNC;
          lead_d  = '0;
        end else if (bit_vld_c) begin
          shreg_d = {bit_val_c, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            state_d = WAIT_START;
            stop_d  = '0;
            wr_d    = !full_q;
            data_d  = {bit_val_c, shreg_q[7:1]};
          end
        end
      end
      WAIT_START: begin
        if (gap_c) begin
          state_d = SYNC;
          lead_d  = '0;
        end else if (phase_err_c) begin
          ferr_d  = 1'b1;
          state_d = SYNC;
          lead_d  = '0;
        end else if (bit_vld_c) begin
          if (bit_val_c) begin
            if (stop_q != 2'd3) stop_d = stop_q + 2'd1;
          end else if (stop_q >= 2'd2) begin
            state_d = DATA;
            bcnt_d  = '0;
          end else begin
            ferr_d  = 1'b1;
            state_d = SYNC;
            lead_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!motor_i) begin
      state_d = IDLE;
      half_d  = 1'b0;
      bcnt_d  = '0;
      wr_d    = 1'b0;
    end

    // Rewind overrides everything, including a byte completing this cycle
    if (rewind_i) begin
      state_d = motor_i ? SYNC : IDLE;
      half_d  = 1'b0;
      lead_d  = '0;
      bcnt_d  = '0;
      wr_d    = 1'b0;
      addr_d  = '0;
      full_d  = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  assign wr_o    = wr_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign full_o  = full_q;
  assign ferr_o  = ferr_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cas_writer.sv
// Directed bench for cas_writer with scaled tick thresholds; a scoreboard queue
// holds the writes each transmitted frame should produce.
module tb_cas_writer;

  localparam int unsigned AW         = 4;
  localparam int unsigned SHORT_MIN  = 12;
  localparam int unsigned LONG_THR   = 36;
  localparam int unsigned GAP_MAX    = 80;
  localparam int unsigned LEADER_MIN = 8;
  localparam int          T_S        = 24;
  localparam int          T_L        = 40;
  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_SYNC    = 2'd1;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          clk_en  = 1'b0;
  logic          tap     = 1'b0;
  logic          motor   = 1'b0;
  logic          rewind  = 1'b0;
  logic          wr;
  logic [AW-1:0] addr;
  logic [7:0]    data;
  logic          full;
  logic          ferr;
  logic [1:0]    state;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } exp_t;

  exp_t          exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [AW-1:0] exp_addr = '0;
  logic          prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  cas_writer #(
    .AW(AW), .SHORT_MIN(SHORT_MIN), .LONG_THR(LONG_THR),
    .GAP_MAX(GAP_MAX), .LEADER_MIN(LEADER_MIN)
  ) dut (
    .clk_i(clk_sys), .reset_n_i(reset_n), .clk_en_i(clk_en), .tap_i(tap),
    .motor_i(motor), .rewind_i(rewind), .wr_o(wr), .addr_o(addr),
    .data_o(data), .full_o(full), .ferr_o(ferr), .state_o(state)
  );

  always #5 clk_sys = ~clk_sys;

  // Tick enable on every other clock
  always @(negedge clk_sys) clk_en = ~clk_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every write must match the oldest expected one
  always @(negedge clk_sys) begin
    if (prev_wr) begin
      check("addr_step", 32'(addr), (prev_addr == '1) ? 32'(prev_addr) : 32'(prev_addr) + 32'd1);
      check("full_after_wr", 32'(full), 32'(prev_addr == '1));
    end
    if (wr) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL unexpected_wr: observed addr 0x%0h data 0x%0h expected no write", addr, data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(addr), 32'(e.a));
        check("wr_data", 32'(data), 32'(e.d));
      end
    end
    prev_wr   = wr;
    prev_addr = addr;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic cyc(input int t);
    tap = 1'b1; wait_clk(t);
    tap = 1'b0; wait_clk(t);
  endtask

  // Cycle with a short low dip ending 20 clocks after the real rising edge
  task automatic cyc_glitch(input int t);
    tap = 1'b1; wait_clk(18);
    tap = 1'b0; wait_clk(2);
    tap = 1'b1; wait_clk(t - 20);
    tap = 1'b0; wait_clk(t);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin cyc(T_S); cyc(T_S); end
    else   cyc(T_L);
  endtask

  task automatic leader(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic frame(input logic [7:0] b, input int nstop, input logic expect_wr);
    if (expect_wr) begin
      exp_q.push_back('{a: exp_addr, d: b});
      exp_addr = exp_addr + AW'(1);
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    for (int i = 0; i < nstop; i++) send_bit(1'b1);
  endtask

  task automatic gap();
    tap = 1'b0;
    wait_clk(2 * int'(GAP_MAX) + 40);
  endtask

  task automatic do_rewind();
    rewind = 1'b1; wait_clk(2);
    rewind = 1'b0; wait_clk(2);
    exp_addr = '0;
  endtask

  initial begin
    // Reset
    wait_clk(3);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    reset_n = 1'b1;
    wait_clk(2);
    motor = 1'b1;
    wait_clk(3);
    check("motor_on_state", 32'(state), 32'(ST_SYNC));

    // Single frame after leader
    gap();
    leader(12);
    frame(8'h5A, 2, 1'b1);
    gap();
    check("t1_addr", 32'(addr), 32'd1);
    check("t1_ferr", 32'(ferr), 32'd0);
    check("t1_pending", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames then end of block
    do_rewind();
    check("rewind_addr", 32'(addr), 32'd0);
    leader(12);
    frame(8'h00, 2, 1'b1);
    frame(8'hFF, 2, 1'b1);
    frame(8'hA5, 2, 1'b1);
    gap();
    check("t2_addr", 32'(addr), 32'd3);
    check("t2_state", 32'(state), 32'(ST_SYNC));
    check("t2_ferr", 32'(ferr), 32'd0);
    check("t2_pending", 32'(exp_q.size()), 32'd0);

    // Only one stop bit before the next start
    leader(12);
    frame(8'h11, 1, 1'b1);
    frame(8'h22, 2, 1'b0);
    gap();
    check("t3_ferr", 32'(ferr), 32'd1);
    check("t3_state", 32'(state), 32'(ST_SYNC));
    check("t3_addr", 32'(addr), 32'd4);
    check("t3_pending", 32'(exp_q.size()), 32'd0);

    // Glitches inside an S and an L cycle are ignored
    do_rewind();
    check("t4_ferr_clr", 32'(ferr), 32'd0);
    leader(12);
    exp_q.push_back('{a: exp_addr, d: 8'h3C});
    exp_addr = exp_addr + AW'(1);
    send_bit(1'b0);
    cyc_glitch(T_L);
    send_bit(1'b0);
    cyc(T_S); cyc_glitch(T_S);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    gap();
    check("t4_ferr", 32'(ferr), 32'd0);
    check("t4_addr", 32'(addr), 32'd1);
    check("t4_pending", 32'(exp_q.size()), 32'd0);

    // Fill the 16-entry RAM, one extra frame must not be written
    do_rewind();
    leader(12);
    for (int i = 0; i < 16; i++) frame(8'(8'h80 + i), 2, 1'b1);
    frame(8'hEE, 2, 1'b0);
    gap();
    check("t5_full", 32'(full), 32'd1);
    check("t5_addr", 32'(addr), 32'd15);
    check("t5_pending", 32'(exp_q.size()), 32'd0);

    // Motor drops mid-byte: IDLE, partial byte dropped, address kept
    leader(12);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    motor = 1'b0;
    wait_clk(3);
    check("t6_idle", 32'(state), 32'(ST_IDLE));
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    check("t6_idle_hold", 32'(state), 32'(ST_IDLE));
    check("t6_addr_kept", 32'(addr), 32'd15);
    check("t6_full_kept", 32'(full), 32'd1);

    // Rewind collides with a completing byte
    motor = 1'b1;
    do_rewind();
    check("t6_rew_addr", 32'(addr), 32'd0);
    check("t6_rew_full", 32'(full), 32'd0);
    gap();
    leader(12);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    tap = 1'b1; wait_clk(1);
    rewind = 1'b1; wait_clk(3);
    rewind = 1'b0; wait_clk(T_S - 4);
    tap = 1'b0; wait_clk(T_S);
    check("t6_col_state", 32'(state), 32'(ST_SYNC));
    check("t6_col_addr", 32'(addr), 32'd0);
    check("t6_col_ferr", 32'(ferr), 32'd0);
    check("t6_col_full", 32'(full), 32'd0);
    motor = 1'b0;
    wait_clk(3);
    check("t6_final_state", 32'(state), 32'(ST_IDLE));
    wait_clk(10);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
